uart_rx_cmd_parser: RTL and testbench
=====================================

Name: uart_rx_cmd_parser

Overview:
Sits directly downstream of the UART receiver. Consumes its byte stream (P_DATA, Data_Valid, PAR_Err, Frame_Err) and assembles multi-byte command frames. Emits one decoded command per frame to the system controller over a valid/ready handshake. Handles corrupted bytes, unknown opcodes, inter-byte timeout and back-pressure.

Parameters:
ADDR_W, 4, register-file address width; the low ADDR_W bits of the address byte are used and the upper bits are ignored.
TIMEOUT_CYC, 1000, idle CLK cycles allowed between bytes of one frame (must be ≥2).
ERR_CNT_W, 8, width of the saturating error counter.

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
rx_data  in  8  received byte (P_DATA)
rx_valid  in  1  one-cycle pulse, byte valid (Data_Valid)
rx_par_err  in  1  parity error for the current byte; sampled only with rx_valid
rx_frame_err  in  1  stop-bit error for the current byte; sampled only with rx_valid
cmd_valid  out  1  decoded command available
cmd_ready  in  1  consumer accepts the command
cmd_type  out  2  0 = RF_WR, 1 = RF_RD, 2 = ALU_OPS, 3 = ALU_NOP
cmd_addr  out  ADDR_W  register address (RF_WR, RF_RD)
cmd_wdata  out  8  write data (RF_WR)
cmd_op_a  out  8  ALU operand A (ALU_OPS)
cmd_op_b  out  8  ALU operand B (ALU_OPS)
cmd_fun  out  4  ALU function, rx_data[3:0] of the fun byte (ALU_OPS, ALU_NOP)
err_pulse  out  1  one-cycle pulse on any dropped byte or aborted frame
err_cnt  out  ERR_CNT_W  saturating count of err_pulse events

Behaviour:
- Reset: state IDLE; cmd_valid=0, err_pulse=0, err_cnt=0; all cmd_* payload outputs = 0; timeout counter = 0.
- Frames (first byte = opcode):
  - 0xAA addr data → RF_WR
  - 0xBB addr → RF_RD
  - 0xCC A B fun → ALU_OPS
  - 0xDD fun → ALU_NOP
- States: IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN, HOLD.
- Transitions, each advancing only on a clean rx_valid (no parity or frame error):
  - IDLE: 0xAA or 0xBB → GET_ADDR; 0xCC → GET_OPA; 0xDD → GET_FUN; any other byte → stay IDLE and raise err_pulse.
  - GET_ADDR: if opcode was 0xAA → GET_WDATA; if 0xBB → HOLD.
  - GET_WDATA → HOLD.
  - GET_OPA → GET_OPB.
  - GET_OPB → GET_FUN.
  - GET_FUN → HOLD.
- Payload fields are registered as their bytes arrive. Fields not used by the command type keep their previous values and must not be relied upon.
- Latency: cmd_valid rises in the cycle after the rx_valid of the final byte.
- HOLD:
  - cmd_valid=1; payload is stable until the handshake.
  - On cmd_valid & cmd_ready, the next state is IDLE and cmd_valid deasserts the next cycle.
  - A byte that arrives while in HOLD without cmd_ready is dropped and raises err_pulse.
  - A byte that arrives in the same cycle as the handshake is processed as an IDLE opcode, so back-to-back frames are not lost.
  - The timeout counter does not run in HOLD.
- Errored byte (rx_valid & (rx_par_err | rx_frame_err)) in any state except HOLD: byte discarded, next state IDLE, err_pulse. A partial frame is abandoned.
- Timeout:
  - The counter runs only in GET_* states and clears on each rx_valid and on entry to IDLE.
  - When it reaches TIMEOUT_CYC-1 without an rx_valid: next state IDLE, err_pulse.
  - An rx_valid in that same cycle takes priority over the timeout.
- err_cnt increments by 1 with each err_pulse and saturates at all-ones; at most one increment per cycle.
- RST asserted mid-frame or in HOLD: everything returns to reset values on the next edge, and the pending command is lost.

Decomposition:
- Package uart_cmd_pkg holds:
  - opcode constants: OP_RF_WR=0xAA, OP_RF_RD=0xBB, OP_ALU_OPS=0xCC, OP_ALU_NOP=0xDD
  - cmd_type encodings
  - state encoding
- One sub-module, cmd_timeout_cnt: clear/enable inputs, expire pulse output, parameterised by TIMEOUT_CYC.

Test Plan:
- Write frame: clean bytes AA,05,3C with cmd_ready=1 → one cycle after the 3C byte: cmd_valid=1, type=0, addr=5, wdata=0x3C; then returns to IDLE; err_cnt=0.
- ALU frame with back-pressure: CC,12,34,07 with cmd_ready=0 for 20 cycles → cmd_valid held for 21 cycles with op_a=0x12, op_b=0x34, fun=7; an extra byte sent during the stall → err_pulse, err_cnt=1, payload unchanged.
- Errored byte: BB then 03 with rx_par_err=1 → no cmd_valid, err_cnt=1; a following DD,02 → ALU_NOP with fun=2.
- Timeout: AA,01 then silence for TIMEOUT_CYC cycles → err_pulse exactly at expiry; a subsequent BB,09 → RF_RD with addr=9.
- Boundaries: unknown opcode 0x55 → err_pulse, stays IDLE. 300 consecutive error events → err_cnt=255. Handshake in the same cycle as opcode 0xDD → first command accepted and second frame starts.
- Reset mid-frame: send CC,11 then pulse RST → all outputs zero; the remaining bytes 22,03 are ignored or treated as opcodes (0x22 unknown, so err_pulse).

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, command-type encodings and FSM state codes for the
// UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] OP_RF_WR   = 8'hAA;
  localparam logic [7:0] OP_RF_RD   = 8'hBB;
  localparam logic [7:0] OP_ALU_OPS = 8'hCC;
  localparam logic [7:0] OP_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    CMD_RF_WR   = 2'd0,
    CMD_RF_RD   = 2'd1,
    CMD_ALU_OPS = 2'd2,
    CMD_ALU_NOP = 2'd3
  } cmd_type_e;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_WDATA = 3'd2;
  localparam logic [2:0] S_GET_OPA   = 3'd3;
  localparam logic [2:0] S_GET_OPB   = 3'd4;
  localparam logic [2:0] S_GET_FUN   = 3'd5;
  localparam logic [2:0] S_HOLD      = 3'd6;

  function automatic logic is_get_state(input logic [2:0] s);
    return (s == S_GET_ADDR) || (s == S_GET_WDATA) || (s == S_GET_OPA) ||
           (s == S_GET_OPB)  || (s == S_GET_FUN);
  endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Inter-byte watchdog: counts enabled idle cycles and flags the cycle in
// which the count sits at TIMEOUT_CYC-1 without being cleared.
module cmd_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  assign expire = en & ~clr & (cnt == TC);

  // Parks at the terminal value so a stalled enable cannot wrap around.
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt <= '0;
    end else if (en && (cnt != TC)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_cmd_parser.sv
// Assembles UART bytes into command frames and hands one decoded command
// per frame to the controller over a valid/ready handshake.
//
// state       | meaning
// S_IDLE      | waiting for an opcode byte
// S_GET_ADDR  | waiting for the address byte (RF_WR / RF_RD)
// S_GET_WDATA | waiting for the write-data byte (RF_WR)
// S_GET_OPA   | waiting for ALU operand A
// S_GET_OPB   | waiting for ALU operand B
// S_GET_FUN   | waiting for the ALU function byte (ALU_OPS / ALU_NOP)
// S_HOLD      | command presented, waiting for cmd_ready
module uart_rx_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_par_err,
  input  logic                 rx_frame_err,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_type,
  output logic [ADDR_W-1:0]    cmd_addr,
  output logic [7:0]           cmd_wdata,
  output logic [7:0]           cmd_op_a,
  output logic [7:0]           cmd_op_b,
  output logic [3:0]           cmd_fun,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [2:0] state, state_nxt;
  logic       byte_ok, byte_bad, as_idle, in_get;
  logic       tmo_clr, tmo_expire, err_evt;
  logic       ld_type, ld_addr, ld_wdata, ld_opa, ld_opb, ld_fun;
  cmd_type_e  type_nxt;

  assign byte_ok   = rx_valid & ~rx_par_err & ~rx_frame_err;
  assign byte_bad  = rx_valid & (rx_par_err | rx_frame_err);
  assign in_get    = is_get_state(state);
  // A handshake in HOLD frees the parser in the same cycle, so that cycle's
  // byte is decoded as an opcode instead of being lost.
  assign as_idle   = (state == S_IDLE) | ((state == S_HOLD) & cmd_ready);
  assign cmd_valid = (state == S_HOLD);
  assign tmo_clr   = rx_valid | ~in_get;

  cmd_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmo_clr),
    .en     (in_get),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    ld_type   = 1'b0;
    ld_addr   = 1'b0;
    ld_wdata  = 1'b0;
    ld_opa    = 1'b0;
    ld_opb    = 1'b0;
    ld_fun    = 1'b0;
    type_nxt  = CMD_ALU_NOP;

    if ((state == S_HOLD) && !cmd_ready) begin
      err_evt = rx_valid;
    end else if (as_idle) begin
      state_nxt = S_IDLE;
      if (byte_bad) begin
        err_evt = 1'b1;
      end else if (byte_ok) begin
        case (rx_data)
          OP_RF_WR: begin
            ld_type = 1'b1; type_nxt = CMD_RF_WR; state_nxt = S_GET_ADDR;
          end
          OP_RF_RD: begin
            ld_type = 1'b1; type_nxt = CMD_RF_RD; state_nxt = S_GET_ADDR;
          end
          OP_ALU_OPS: begin
            ld_type = 1'b1; type_nxt = CMD_ALU_OPS; state_nxt = S_GET_OPA;
          end
          OP_ALU_NOP: begin
            ld_type = 1'b1; type_nxt = CMD_ALU_NOP; state_nxt = S_GET_FUN;
          end
          default: err_evt = 1'b1;
        endcase
      end
    end else begin
      if (byte_bad) begin
        state_nxt = S_IDLE;
        err_evt   = 1'b1;
      end else if (byte_ok) begin
        case (state)
          S_GET_ADDR: begin
            ld_addr   = 1'b1;
            state_nxt = (cmd_type == CMD_RF_WR) ? S_GET_WDATA : S_HOLD;
          end
          S_GET_WDATA: begin ld_wdata = 1'b1; state_nxt = S_HOLD;    end
          S_GET_OPA:   begin ld_opa   = 1'b1; state_nxt = S_GET_OPB; end
          S_GET_OPB:   begin ld_opb   = 1'b1; state_nxt = S_GET_FUN; end
          S_GET_FUN:   begin ld_fun   = 1'b1; state_nxt = S_HOLD;    end
          default:     state_nxt = S_IDLE;
        endcase
      end else if (tmo_expire) begin
        state_nxt = S_IDLE;
        err_evt   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      cmd_type  <= '0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_op_a  <= '0;
      cmd_op_b  <= '0;
      cmd_fun   <= '0;
    end else begin
      state     <= state_nxt;
      err_pulse <= err_evt;
      if (err_evt && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
      if (ld_type)  cmd_type  <= type_nxt;
      if (ld_addr)  cmd_addr  <= rx_data[ADDR_W-1:0];
      if (ld_wdata) cmd_wdata <= rx_data;
      if (ld_opa)   cmd_op_a  <= rx_data;
      if (ld_opb)   cmd_op_b  <= rx_data;
      if (ld_fun)   cmd_fun   <= rx_data[3:0];
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_parser.sv
// Scoreboard bench for uart_rx_cmd_parser: directed scenarios followed by
// randomized frames checked against a frame-level expectation model.
module tb_uart_rx_cmd_parser;

  localparam int TMO = 40;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, rx_par_err = 1'b0, rx_frame_err = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid, err_pulse;
  logic [1:0] cmd_type;
  logic [3:0] cmd_addr, cmd_fun;
  logic [7:0] cmd_wdata, cmd_op_a, cmd_op_b, err_cnt;

  typedef struct packed {
    logic [1:0] t;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] fun;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0, exp_err = 0, err_seen = 0;
  bit   rnd_ready = 1'b0;

  uart_rx_cmd_parser #(.ADDR_W(4), .TIMEOUT_CYC(TMO), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_par_err(rx_par_err), .rx_frame_err(rx_frame_err),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_op_a(cmd_op_a),
    .cmd_op_b(cmd_op_b), .cmd_fun(cmd_fun), .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] t, input logic [3:0] a, input logic [7:0] w,
                              input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
    exp_t e;
    e.t = t; e.addr = a; e.wdata = w; e.opa = oa; e.opb = ob; e.fun = f;
    return e;
  endfunction

  // Monitor: every accepted command is popped and compared to the queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (err_pulse) err_seen++;
      if (cmd_valid && cmd_ready) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_cmd actual type=%0d required none", cmd_type);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cmd_type", cmd_type, e.t);
          case (e.t)
            2'd0: begin chk("wr_addr", cmd_addr, e.addr); chk("wr_wdata", cmd_wdata, e.wdata); end
            2'd1: chk("rd_addr", cmd_addr, e.addr);
            2'd2: begin
              chk("alu_op_a", cmd_op_a, e.opa);
              chk("alu_op_b", cmd_op_b, e.opb);
              chk("alu_fun", cmd_fun, e.fun);
            end
            default: chk("nop_fun", cmd_fun, e.fun);
          endcase
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (rnd_ready) begin
      #1;
      cmd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic pe, input logic fe);
    rx_data = d; rx_valid = 1'b1; rx_par_err = pe; rx_frame_err = fe;
    tick();
    rx_valid = 1'b0; rx_par_err = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1; rx_valid = 1'b0;
    tick(); tick();
    RST = 1'b0;
    exp_err = 0; err_seen = 0;
    q.delete();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin tick(); n++; end
    if (q.size() != 0) begin
      chk(name, q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    logic [7:0] b[4];
    int len, t, k, sel, vcnt, first, npulse;

    // Reset state
    tick(); do_reset();
    @(negedge CLK);
    chk("rst_cmd_valid", cmd_valid, 0); chk("rst_err_pulse", err_pulse, 0);
    chk("rst_err_cnt", err_cnt, 0);     chk("rst_cmd_type", cmd_type, 0);
    chk("rst_addr", cmd_addr, 0);       chk("rst_wdata", cmd_wdata, 0);
    chk("rst_op_a", cmd_op_a, 0);       chk("rst_op_b", cmd_op_b, 0);
    chk("rst_fun", cmd_fun, 0);
    tick();

    // Write frame
    cmd_ready = 1'b1;
    q.push_back(mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0));
    send_byte(8'hAA, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h3C, 0, 0);
    @(negedge CLK); chk("wr_latency_valid", cmd_valid, 1);
    tick();
    @(negedge CLK); chk("wr_back_idle", cmd_valid, 0);
    chk("wr_err_cnt", err_cnt, 0);
    tick(); drain("wr_drain");

    // ALU frame under back-pressure with a dropped byte
    do_reset();
    cmd_ready = 1'b0;
    q.push_back(mk(2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h7));
    send_byte(8'hCC, 0, 0); send_byte(8'h12, 0, 0); send_byte(8'h34, 0, 0); send_byte(8'h07, 0, 0);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin rx_data = 8'h99; rx_valid = 1'b1; end
      @(negedge CLK);
      if (cmd_valid) vcnt++;
      if (i == 6) chk("stall_drop_pulse", err_pulse, 1);
      tick();
      rx_valid = 1'b0;
    end
    exp_err = 1;
    cmd_ready = 1'b1;
    @(negedge CLK); if (cmd_valid) vcnt++;
    tick();
    @(negedge CLK); chk("stall_release", cmd_valid, 0);
    chk("stall_valid_cycles", vcnt, 21);
    chk("stall_err_cnt", err_cnt, exp_err);
    tick(); drain("stall_drain");

    // Errored byte abandons the frame
    do_reset();
    cmd_ready = 1'b1;
    send_byte(8'hBB, 0, 0); send_byte(8'h03, 1, 0);
    exp_err = 1;
    idle(3);
    chk("par_err_cnt", err_cnt, exp_err);
    q.push_back(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2));
    send_byte(8'hDD, 0, 0); send_byte(8'h02, 0, 0);
    idle(3); drain("par_drain");
    chk("par_queue_empty", q.size(), 0);

    // Inter-byte timeout
    do_reset();
    send_byte(8'hAA, 0, 0); send_byte(8'h01, 0, 0);
    first = 0; npulse = 0;
    for (int j = 1; j <= TMO + 3; j++) begin
      @(negedge CLK);
      if (err_pulse) begin npulse++; if (first == 0) first = j; end
    end
    tick();
    exp_err = 1;
    chk("tmo_pulse_cycle", first, TMO + 1);
    chk("tmo_pulse_count", npulse, 1);
    chk("tmo_err_cnt", err_cnt, exp_err);
    q.push_back(mk(2'd1, 4'h9, 8'h00, 8'h00, 8'h00, 4'h0));
    send_byte(8'hBB, 0, 0); send_byte(8'h09, 0, 0);
    idle(3); drain("tmo_drain");

    // Unknown opcode stays in IDLE
    do_reset();
    send_byte(8'h55, 0, 0);
    @(negedge CLK); chk("unknown_op_pulse", err_pulse, 1);
    tick();
    exp_err = 1;
    q.push_back(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF));
    send_byte(8'hDD, 0, 0); send_byte(8'h0F, 0, 0);
    idle(3); drain("unknown_drain");
    chk("unknown_err_cnt", err_cnt, exp_err);

    // Handshake coincides with the next opcode
    do_reset();
    cmd_ready = 1'b0;
    q.push_back(mk(2'd2, 4'h0, 8'h00, 8'h01, 8'h02, 4'h3));
    q.push_back(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4));
    send_byte(8'hCC, 0, 0); send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h03, 0, 0);
    idle(3);
    cmd_ready = 1'b1;
    send_byte(8'hDD, 0, 0);
    cmd_ready = 1'b0;
    send_byte(8'h04, 0, 0);
    idle(2);
    cmd_ready = 1'b1;
    idle(2); drain("b2b_drain");
    chk("b2b_err_cnt", err_cnt, 0);

    // Reset in the middle of a frame
    do_reset();
    cmd_ready = 1'b1;
    send_byte(8'hCC, 0, 0); send_byte(8'h11, 0, 0);
    do_reset();
    @(negedge CLK);
    chk("midrst_valid", cmd_valid, 0); chk("midrst_op_a", cmd_op_a, 0);
    chk("midrst_type", cmd_type, 0);   chk("midrst_err_cnt", err_cnt, 0);
    tick();
    send_byte(8'h22, 0, 0); send_byte(8'h03, 0, 0);
    exp_err = 2;
    idle(2);
    chk("midrst_after_err_cnt", err_cnt, exp_err);

    // Randomized frames
    do_reset();
    rnd_ready = 1'b1;
    for (int f = 0; f < 150; f++) begin
      t = $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom_range(0, 255));
      case (t)
        0: begin b[0] = 8'hAA; len = 3; end
        1: begin b[0] = 8'hBB; len = 2; end
        2: begin b[0] = 8'hCC; len = 4; end
        default: begin b[0] = 8'hDD; len = 2; end
      endcase
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        do b[0] = 8'($urandom_range(0, 255));
        while (b[0] == 8'hAA || b[0] == 8'hBB || b[0] == 8'hCC || b[0] == 8'hDD);
        send_byte(b[0], 0, 0);
        exp_err++;
      end else if (sel == 1) begin
        k = $urandom_range(0, len - 1);
        for (int i = 0; i < k; i++) begin send_byte(b[i], 0, 0); idle($urandom_range(0, 5)); end
        sel = $urandom_range(1, 3);
        send_byte(b[k], sel[0], sel[1]);
        exp_err++;
      end else if (sel == 2) begin
        k = $urandom_range(1, len - 1);
        for (int i = 0; i < k; i++) begin send_byte(b[i], 0, 0); idle($urandom_range(0, 5)); end
        idle(TMO + 2);
        exp_err++;
      end else begin
        case (t)
          0: q.push_back(mk(2'd0, b[1][3:0], b[2], 8'h00, 8'h00, 4'h0));
          1: q.push_back(mk(2'd1, b[1][3:0], 8'h00, 8'h00, 8'h00, 4'h0));
          2: q.push_back(mk(2'd2, 4'h0, 8'h00, b[1], b[2], b[3][3:0]));
          default: q.push_back(mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, b[1][3:0]));
        endcase
        for (int i = 0; i < len; i++) begin
          send_byte(b[i], 0, 0);
          if (i < len - 1) idle($urandom_range(0, 5));
        end
        drain("rnd_drain");
      end
      idle($urandom_range(0, 3));
    end
    rnd_ready = 1'b0;
    idle(2);
    cmd_ready = 1'b1;
    idle(3);
    chk("rnd_queue_empty", q.size(), 0);
    chk("rnd_err_cnt", err_cnt, exp_err);
    chk("rnd_err_pulses", err_seen, exp_err);

    // Saturation of the error counter
    do_reset();
    for (int i = 0; i < 300; i++) send_byte(8'h55, 0, 0);
    idle(3);
    chk("sat_err_cnt", err_cnt, 255);
    chk("sat_err_pulses", err_seen, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
